stdout_line_arbiter: RTL and testbench



---
 rtl/stdout_line_arbiter_pkg.sv | 9 +
 rtl/stdout_line_arbiter_picker.sv | 33 +++
 rtl/stdout_line_arbiter.sv | 124 ++++++++++++
 tb/tb_stdout_line_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stdout_line_arbiter_pkg.sv
// Shared types and constants for the line-atomic stdout arbiter.
package stdout_pkg;
  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_e;

  localparam logic [7:0] NEWLINE = 8'h0A;
  localparam int ID_W_DEFAULT = 3;

  typedef logic [ID_W_DEFAULT-1:0] id_t;
endpackage

// File: rtl/stdout_line_arbiter_picker.sv
// Round-robin first-set search over the request vector, starting at the pointer.
module stdout_rr_picker
  import stdout_pkg::*;
#(
  parameter int N_REQ    = 8,
  parameter int ID_WIDTH = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0]    req_valid_i,
  input  logic [ID_WIDTH-1:0] rr_ptr_i,
  output logic                pick_valid_o,
  output logic [ID_WIDTH-1:0] pick_idx_o
);

  int                  w_idx;
  logic [ID_WIDTH-1:0] w_sel;

  // Scan from farthest to nearest so the nearest set bit is the one that sticks.
  always_comb begin
    pick_valid_o = 1'b0;
    pick_idx_o   = '0;
    w_idx        = 0;
    w_sel        = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = (int'(rr_ptr_i) + k) % N_REQ;
      w_sel = ID_WIDTH'(w_idx);
      if (req_valid_i[w_sel]) begin
        pick_valid_o = 1'b1;
        pick_idx_o   = w_sel;
      end
    end
  end

endmodule

// File: rtl/stdout_line_arbiter.sv
// Shares one byte-wide stdout sink among N_REQ sources; a grant is held until the
// line ends (newline, length limit or owner timeout), so lines never interleave.
module stdout_line_arbiter
  import stdout_pkg::*;
#(
  parameter int N_REQ    = 8,
  parameter int ID_WIDTH = $clog2(N_REQ),
  parameter int MAX_LINE = 128,
  parameter int TIMEOUT  = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_REQ-1:0]     req_valid_i,
  input  logic [N_REQ*8-1:0]   req_data_i,
  output logic [N_REQ-1:0]     req_ready_o,
  output logic                 out_valid_o,
  output logic [7:0]           out_data_o,
  output logic [ID_WIDTH-1:0]  out_id_o,
  output logic                 out_last_o,
  input  logic                 out_ready_i,
  output logic                 busy_o,
  output logic                 timeout_o
);

  localparam int LEN_W  = $clog2(MAX_LINE) + 1;
  localparam int IDLE_W = $clog2(TIMEOUT) + 1;

  state_e              r_state;
  state_e              w_next;
  logic [ID_WIDTH-1:0] r_owner;
  logic [ID_WIDTH-1:0] r_rr_ptr;
  logic [LEN_W-1:0]    r_len_cnt;
  logic [IDLE_W-1:0]   r_idle_cnt;

  logic                w_pick_valid;
  logic [ID_WIDTH-1:0] w_pick_idx;
  logic                w_own_valid;
  logic [7:0]          w_own_data;
  logic                w_xfer;

  stdout_rr_picker #(
    .N_REQ    (N_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_picker (
    .req_valid_i  (req_valid_i),
    .rr_ptr_i     (r_rr_ptr),
    .pick_valid_o (w_pick_valid),
    .pick_idx_o   (w_pick_idx)
  );

  assign w_own_valid = req_valid_i[r_owner];
  assign w_own_data  = req_data_i[{r_owner, 3'b000} +: 8];
  assign w_xfer      = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_pick_valid) w_next = LOCK;
      LOCK:    if ((w_xfer && out_last_o) || timeout_o) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs are forced to zero outside a grant so the sink sees a clean idle bus.
  always_comb begin
    out_valid_o = 1'b0;
    out_data_o  = '0;
    out_id_o    = '0;
    out_last_o  = 1'b0;
    req_ready_o = '0;
    busy_o      = 1'b0;
    timeout_o   = 1'b0;
    if (r_state == LOCK) begin
      out_valid_o          = w_own_valid;
      out_data_o           = w_own_data;
      out_id_o             = r_owner;
      out_last_o           = (w_own_data == NEWLINE) || (r_len_cnt == LEN_W'(MAX_LINE - 1));
      req_ready_o[r_owner] = out_ready_i;
      busy_o               = 1'b1;
      timeout_o            = !(w_own_valid && out_ready_i) &&
                             (r_idle_cnt == IDLE_W'(TIMEOUT - 1));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_len_cnt  <= '0;
      r_idle_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_owner    <= w_pick_idx;
            r_len_cnt  <= '0;
            r_idle_cnt <= '0;
          end
        end
        LOCK: begin
          if (w_xfer) begin
            r_len_cnt  <= r_len_cnt + 1'b1;
            r_idle_cnt <= '0;
          end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
          end
          if (w_next == IDLE) begin
            r_rr_ptr <= (r_owner == ID_WIDTH'(N_REQ - 1)) ? '0 : r_owner + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stdout_line_arbiter.sv
// Randomized scoreboard bench for stdout_line_arbiter with directed scenario checks.
module tb_stdout_line_arbiter;
  localparam int N   = 8;
  localparam int IDW = 3;
  localparam int ML  = 4;
  localparam int TO  = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N*8-1:0]   req_data = '0;
  logic [N-1:0]     req_ready;
  logic             out_valid;
  logic [7:0]       out_data;
  logic [IDW-1:0]   out_id;
  logic             out_last;
  logic             out_ready = 1'b1;
  logic             busy;
  logic             tmo;

  stdout_line_arbiter #(
    .N_REQ    (N),
    .ID_WIDTH (IDW),
    .MAX_LINE (ML),
    .TIMEOUT  (TO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_id_o    (out_id),
    .out_last_o  (out_last),
    .out_ready_i (out_ready),
    .busy_o      (busy),
    .timeout_o   (tmo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic rnd_ready = 1'b0;
  logic [N-1:0] hs = '0;
  logic [7:0] src_q [N][$];

  int         exp_id[$];
  logic [7:0] exp_data[$];
  logic       exp_last[$];
  int         log_id[$];
  logic [7:0] log_data[$];
  logic       log_last[$];
  int         log_cyc[$];

  // Reference model state: owner < 0 means nobody holds the sink.
  int m_owner = -1, m_ptr = 0, m_len = 0, m_idle = 0;
  logic e_busy = 0, e_to = 0, e_valid = 0, e_last = 0;
  int e_id = 0;
  logic [N-1:0] e_ready = '0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic chk_log(string nm, int k, int id, logic [7:0] d, logic l);
    if (k >= log_id.size()) begin
      checks++;
      errors++;
      $display("FAIL %s[%0d]: no transfer logged, expected id %0d data %02h", nm, k, id, d);
    end else begin
      chk({nm, "_id"}, log_id[k], id);
      chk({nm, "_data"}, {24'h0, log_data[k]}, {24'h0, d});
      chk({nm, "_last"}, {31'h0, log_last[k]}, {31'h0, l});
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Sources: present the head of each queue, retire it after a handshake.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      req_valid[i] = (src_q[i].size() > 0);
      req_data[i*8 +: 8] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
    end
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) hs = req_valid & req_ready;

  // Behavioural model: evaluated once inputs for the cycle are settled.
  always @(posedge clk) begin
    int n_owner, n_ptr, n_len, n_idle;
    logic v, xf;
    logic [7:0] d;
    #3;
    e_valid = 0; e_id = 0; e_last = 0; e_ready = '0; e_busy = 0; e_to = 0;
    n_owner = m_owner; n_ptr = m_ptr; n_len = m_len; n_idle = m_idle;
    if (m_owner < 0) begin
      for (int k = N - 1; k >= 0; k--) begin
        if (req_valid[(m_ptr + k) % N]) n_owner = (m_ptr + k) % N;
      end
      n_len = 0;
      n_idle = 0;
    end else begin
      v = req_valid[m_owner];
      d = req_data[m_owner*8 +: 8];
      e_busy = 1;
      e_valid = v;
      e_id = m_owner;
      e_last = (d == 8'h0A) || (m_len == ML - 1);
      e_ready[m_owner] = out_ready;
      xf = v && out_ready;
      e_to = !xf && (m_idle == TO - 1);
      if (xf) begin
        exp_id.push_back(m_owner);
        exp_data.push_back(d);
        exp_last.push_back(e_last);
        n_len = m_len + 1;
        n_idle = 0;
      end else begin
        n_idle = m_idle + 1;
      end
      if ((xf && e_last) || e_to) begin
        n_owner = -1;
        n_ptr = (m_owner + 1) % N;
      end
    end
    if (rst) begin
      n_owner = -1; n_ptr = 0; n_len = 0; n_idle = 0;
    end
    m_owner = n_owner; m_ptr = n_ptr; m_len = n_len; m_idle = n_idle;
  end

  // Monitor: compare the DUT against the model and the expected-transfer queue.
  always @(negedge clk) begin
    chk("busy", {31'h0, busy}, {31'h0, e_busy});
    chk("timeout", {31'h0, tmo}, {31'h0, e_to});
    chk("out_valid", {31'h0, out_valid}, {31'h0, e_valid});
    chk("out_id", {29'h0, out_id}, e_id);
    chk("out_last", {31'h0, out_last}, {31'h0, e_last});
    chk("req_ready", {24'h0, req_ready}, {24'h0, e_ready});
    if (!e_busy) chk("idle_data", {24'h0, out_data}, 32'h0);
    if (out_valid && out_ready) begin
      log_id.push_back(int'(out_id));
      log_data.push_back(out_data);
      log_last.push_back(out_last);
      log_cyc.push_back(cyc);
      if (exp_id.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL xfer_unexpected: got id %0d data %02h, expected no transfer", out_id, out_data);
      end else begin
        chk("xfer_id", {29'h0, out_id}, exp_id.pop_front());
        chk("xfer_data", {24'h0, out_data}, {24'h0, exp_data.pop_front()});
        chk("xfer_last", {31'h0, out_last}, {31'h0, exp_last.pop_front()});
      end
    end
    if (exp_id.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL xfer_missing: got no transfer, expected id %0d data %02h", exp_id[0], exp_data[0]);
      exp_id.delete(); exp_data.delete(); exp_last.delete();
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_log();
    log_id.delete(); log_data.delete(); log_last.delete(); log_cyc.delete();
  endtask

  task automatic wait_drain(int maxc);
    int n;
    bit empty;
    n = 0;
    empty = 0;
    while (n < maxc && !empty) begin
      @(negedge clk);
      empty = !busy;
      for (int i = 0; i < N; i++) if (src_q[i].size() != 0) empty = 0;
      n++;
    end
    checks++;
    if (!empty) begin
      errors++;
      $display("FAIL drain_timeout: got busy after %0d cycles, expected idle", maxc);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic push_line(int r, int len, bit nl);
    for (int k = 0; k < len; k++) begin
      if (nl && k == len - 1) src_q[r].push_back(8'h0A);
      else src_q[r].push_back(8'($urandom_range(8'h20, 8'h7E)));
    end
  endtask

  initial begin
    int n, tcyc;
    logic [7:0] bp [10];

    // Reset with every requester holding two one-byte lines.
    for (int i = 0; i < N; i++) begin
      src_q[i].push_back(8'h0A);
      src_q[i].push_back(8'h0A);
    end
    repeat (2) step();
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    chk("first_grant_id", {29'h0, out_id}, 32'd0);
    wait_drain(500);
    for (int k = 0; k < 16; k++) chk_log("rr", k, k % 8, 8'h0A, 1'b1);
    if (log_cyc.size() >= 16)
      for (int k = 1; k < 16; k++) chk("rr_gap", log_cyc[k] - log_cyc[k-1], 32'd2);
    clear_log();

    // Two concurrent lines must not interleave.
    step();
    src_q[3].push_back(8'h43); src_q[3].push_back(8'h44); src_q[3].push_back(8'h0A);
    src_q[1].push_back(8'h41); src_q[1].push_back(8'h42); src_q[1].push_back(8'h0A);
    wait_drain(200);
    chk_log("il", 0, 1, 8'h41, 1'b0);
    chk_log("il", 1, 1, 8'h42, 1'b0);
    chk_log("il", 2, 1, 8'h0A, 1'b1);
    chk_log("il", 3, 3, 8'h43, 1'b0);
    chk_log("il", 4, 3, 8'h44, 1'b0);
    chk_log("il", 5, 3, 8'h0A, 1'b1);
    if (log_cyc.size() >= 4) chk("il_gap", log_cyc[3] - log_cyc[2], 32'd2);
    clear_log();

    // Length limit cuts the line after MAX_LINE bytes.
    step();
    for (int k = 0; k < 6; k++) src_q[2].push_back(8'h61 + 8'(k));
    wait_drain(300);
    for (int k = 0; k < 6; k++) chk_log("len", k, 2, 8'h61 + 8'(k), k == 3);
    if (log_cyc.size() >= 5) chk("len_gap", log_cyc[4] - log_cyc[3], 32'd2);
    clear_log();

    // Owner goes silent after one byte and is forcibly released.
    step();
    src_q[5].push_back(8'h78);
    n = 0;
    while (log_id.size() == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    src_q[6].push_back(8'h79);
    src_q[6].push_back(8'h0A);
    n = 0;
    tcyc = -1;
    while (tcyc < 0 && n < 60) begin
      @(negedge clk);
      if (tmo) tcyc = cyc;
      n++;
    end
    if (log_cyc.size() >= 1) chk("to_latency", tcyc - log_cyc[0], 32'd16);
    @(negedge clk);
    chk("to_busy_drop", {31'h0, busy}, 32'd0);
    wait_drain(300);
    chk_log("to", 0, 5, 8'h78, 1'b0);
    chk_log("to", 1, 6, 8'h79, 1'b0);
    chk_log("to", 2, 6, 8'h0A, 1'b1);
    clear_log();

    // Backpressure on a 10-byte line: order and content preserved.
    step();
    rnd_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bp[k] = (k == 9) ? 8'h0A : 8'($urandom_range(8'h20, 8'h7E));
      src_q[0].push_back(bp[k]);
    end
    wait_drain(1000);
    chk("bp_count", log_id.size(), 32'd10);
    for (int k = 0; k < 10 && k < log_id.size(); k++) begin
      chk("bp_id", log_id[k], 32'd0);
      chk("bp_data", {24'h0, log_data[k]}, {24'h0, bp[k]});
    end
    clear_log();

    // Random traffic from all requesters under random backpressure.
    repeat (400) begin
      step();
      if ($urandom_range(0, 3) == 0)
        push_line($urandom_range(0, N - 1), $urandom_range(1, 10), $urandom_range(0, 3) != 0);
    end
    wait_drain(20000);
    chk("final_exp_empty", exp_id.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
